// File: rtl/vx_uop_expander_if.sv
// Valid/ready instruction channel shared by the sequencer and ibuffer sides.
// Payload type is a parameter so the channel stays generic.
interface vx_uop_expander_if #(
  parameter type data_t = logic
);
  logic  valid;
  data_t data;
  logic  ready;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

package vx_uop_pkg;
  localparam int UUID_BITS     = 16;
  localparam int NW_BITS       = 2;
  localparam int NUM_THREADS   = 4;
  localparam int EX_BITS       = 3;
  localparam int INST_OP_BITS  = 4;
  localparam int INST_MOD_BITS = 3;
  localparam int NRI_BITS      = 5;
  localparam int REG_BITS      = NRI_BITS + 1;

  localparam logic [EX_BITS-1:0] EX_ALU    = 3'd0;
  localparam logic [EX_BITS-1:0] EX_LSU    = 3'd1;
  localparam logic [EX_BITS-1:0] EX_SFU    = 3'd2;
  localparam logic [EX_BITS-1:0] EX_FPU    = 3'd3;
  localparam logic [EX_BITS-1:0] EX_TENSOR = 3'd4;

  typedef struct packed {
    logic [UUID_BITS-1:0]     uuid;
    logic [NW_BITS-1:0]       wis;
    logic [NUM_THREADS-1:0]   tmask;
    logic [31:0]              PC;
    logic [EX_BITS-1:0]       ex_type;
    logic [INST_OP_BITS-1:0]  op_type;
    logic [INST_MOD_BITS-1:0] op_mod;
    logic                     wb;
    logic                     use_PC;
    logic                     use_IMM;
    logic [31:0]              imm;
    logic [REG_BITS-1:0]      rd;
    logic [REG_BITS-1:0]      rs1;
    logic [REG_BITS-1:0]      rs2;
    logic [REG_BITS-1:0]      rs3;
  } ibuf_data_t;
endpackage

// File: rtl/vx_uop_expander.sv
// Expands tensor instructions into step/substep uops with generated
// float-register operands; other instructions pass through one stage.
module vx_uop_expander
  import vx_uop_pkg::*;
#(
  parameter logic [EX_BITS-1:0] UOP_EX_TYPE = EX_TENSOR,
  parameter int NUM_SETS     = 4,
  parameter int NUM_STEPS    = 4,
  parameter int NUM_SUBSTEPS = 2,
  parameter int A_BASE       = 0,
  parameter int B_BASE       = 8,
  parameter int C_BASE       = 16
) (
  input  logic clk,
  input  logic reset,
  vx_uop_expander_if.slave  uop_sequencer_if,
  vx_uop_expander_if.master ibuffer_if,
  output logic bad_op
);

  localparam int TOTAL  = NUM_STEPS * NUM_SUBSTEPS;
  localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int SUB_W  = (NUM_SUBSTEPS > 1) ? $clog2(NUM_SUBSTEPS) : 1;
  localparam int SET_W  = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;

  if (A_BASE + TOTAL > (1 << NRI_BITS)) begin : g_chk_a
    $error("A operand range exceeds register file");
  end
  if (B_BASE + TOTAL > (1 << NRI_BITS)) begin : g_chk_b
    $error("B operand range exceeds register file");
  end
  if (C_BASE + NUM_SUBSTEPS > (1 << NRI_BITS)) begin : g_chk_c
    $error("C operand range exceeds register file");
  end
  if (NUM_SETS * NUM_STEPS > (1 << INST_OP_BITS)) begin : g_chk_op
    $error("op_type too narrow for sets x steps");
  end
  if (NUM_SUBSTEPS > (1 << INST_MOD_BITS)) begin : g_chk_mod
    $error("op_mod too narrow for substeps");
  end

  typedef enum logic {
    IDLE,
    EXPAND
  } state_t;

  state_t              state, state_n;
  logic [STEP_W-1:0]   step, step_n;
  logic [SUB_W-1:0]    sub, sub_n;
  logic [SET_W-1:0]    set_q, set_n;
  logic                out_v, out_v_n;
  ibuf_data_t          out_d, out_d_n;

  ibuf_data_t          in_d;
  logic                in_v;
  logic                load;
  logic                busy;
  logic                is_exp;
  logic                is_good;
  logic                last;
  logic                sub_wrap;
  logic                go_exp;
  logic                go_pass;
  logic [STEP_W-1:0]   cur_step;
  logic [SUB_W-1:0]    cur_sub;
  logic [SET_W-1:0]    cur_set;

  function automatic ibuf_data_t make_uop(
    input ibuf_data_t        src,
    input logic [SET_W-1:0]  s,
    input logic [STEP_W-1:0] st,
    input logic [SUB_W-1:0]  sb
  );
    ibuf_data_t          u;
    logic [NRI_BITS-1:0] j;
    j = NRI_BITS'(st) * NRI_BITS'(NUM_SUBSTEPS)
      + NRI_BITS'(sb);
    u = src;
    u.ex_type = UOP_EX_TYPE;
    u.op_type = INST_OP_BITS'(s) * INST_OP_BITS'(NUM_STEPS)
              + INST_OP_BITS'(st);
    u.op_mod  = INST_MOD_BITS'(sb);
    u.wb      = 1'b1;
    u.use_PC  = 1'b0;
    u.use_IMM = 1'b0;
    u.imm     = '0;
    u.rs1     = {1'b1, NRI_BITS'(A_BASE) + j};
    u.rs2     = {1'b1, NRI_BITS'(B_BASE) + j};
    u.rd      = {1'b1, NRI_BITS'(C_BASE) + NRI_BITS'(sb)};
    u.rs3     = u.rd;
    return u;
  endfunction

  assign in_v    = uop_sequencer_if.valid;
  assign in_d    = uop_sequencer_if.data;
  assign load    = !out_v || ibuffer_if.ready;
  assign busy    = (state == EXPAND);
  assign is_exp  = (in_d.ex_type == UOP_EX_TYPE);
  assign is_good = is_exp && (int'(in_d.op_type) < NUM_SETS);

  // The first uop is emitted straight from IDLE at (0,0).
  assign cur_step = busy ? step : '0;
  assign cur_sub  = busy ? sub : '0;
  assign cur_set  = busy ? set_q : SET_W'(in_d.op_type);
  assign sub_wrap = (cur_sub == SUB_W'(NUM_SUBSTEPS - 1));
  assign last     = sub_wrap
                 && (cur_step == STEP_W'(NUM_STEPS - 1));

  assign go_exp  = load && (busy || (in_v && is_good));
  assign go_pass = load && !busy && in_v && !is_good;

  // Input is only acknowledged once its last uop loads.
  assign uop_sequencer_if.ready =
    !reset && load && ((busy || is_good) ? last : 1'b1);
  assign bad_op = !reset && go_pass && is_exp;

  assign ibuffer_if.valid = out_v;
  assign ibuffer_if.data  = out_d;

  always_comb begin
    state_n = state;
    step_n  = step;
    sub_n   = sub;
    set_n   = set_q;
    out_v_n = out_v;
    out_d_n = out_d;
    if (load) begin
      out_v_n = 1'b0;
    end
    unique case (1'b1)
      go_exp: begin
        out_v_n = 1'b1;
        out_d_n = make_uop(in_d, cur_set, cur_step, cur_sub);
        set_n   = cur_set;
        if (last) begin
          state_n = IDLE;
          step_n  = '0;
          sub_n   = '0;
        end else if (sub_wrap) begin
          state_n = EXPAND;
          step_n  = cur_step + STEP_W'(1);
          sub_n   = '0;
        end else begin
          state_n = EXPAND;
          step_n  = cur_step;
          sub_n   = cur_sub + SUB_W'(1);
        end
      end
      go_pass: begin
        out_v_n = 1'b1;
        out_d_n = in_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      step  <= '0;
      sub   <= '0;
      set_q <= '0;
      out_v <= 1'b0;
      out_d <= '0;
    end else begin
      state <= state_n;
      step  <= step_n;
      sub   <= sub_n;
      set_q <= set_n;
      out_v <= out_v_n;
      out_d <= out_d_n;
    end
  end

  a_hold_input: assert property (
    @(posedge clk) disable iff (reset)
    (state == EXPAND) |-> in_v
  );

endmodule
